// File: rtl/pdm_decimator_pkg.sv
// Shared constants and helpers for the PDM receive path.
// AUDIO_W is the PCM width shared with the delta-sigma DAC on the transmit side.
package pdm_decimator_pkg;

    localparam int AUDIO_W            = 8;
    localparam int DECIM_LOG2_DEFAULT = 6;
    localparam logic [AUDIO_W-1:0] AUDIO_FULL_SCALE = 8'hFF;

    // Widest CIC datapath for the largest legal ratio (DECIM_LOG2 = 8 -> 17 bits).
    localparam int CIC_W_MAX = 17;

    // Warm-up tracking: the first frame after reset only primes the comb delays.
    typedef enum logic {
        WARM_FILL = 1'b0,
        WARM_RUN  = 1'b1
    } warm_state_e;

    // Maps a w-bit CIC output (range 0..2^(w-1)) onto unsigned PCM.
    // The single out-of-range code 2^(w-1) (all-ones input) clips to full scale.
    function automatic logic [AUDIO_W-1:0] cic_to_pcm(input logic [CIC_W_MAX-1:0] y,
                                                      input int w);
        logic [CIC_W_MAX-1:0] shifted;
        shifted = y >> (w - 1 - AUDIO_W);
        return y[w-1] ? AUDIO_FULL_SCALE : shifted[AUDIO_W-1:0];
    endfunction

endpackage

// File: rtl/pdm_decimator_if.sv
// Bit-stream input and PCM output bundle of the PDM decimator.
// The slave side is the decimator; the master side drives bits and consumes samples.
interface pdm_decimator_if
    import pdm_decimator_pkg::*;
;
    logic               pdm_in;
    logic               pdm_en;
    logic [AUDIO_W-1:0] data_out;
    logic               data_valid;

    modport master (output pdm_in, output pdm_en, input data_out, input data_valid);
    modport slave  (input pdm_in, input pdm_en, output data_out, output data_valid);

endinterface

// File: rtl/pdm_decimator_cic_comb_stage.sv
// One CIC comb (differentiator): dout = din - din_delayed.
// The delay register only advances when en is high, i.e. once per output frame.
module cic_comb_stage #(
    parameter int W = 13
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] dly_q;
    logic [W-1:0] dly_d;

    // Next delay value: capture the current input on a frame tick, otherwise hold.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        dly_d = dly_q;
        if (en) begin
            dly_d = din;
        end
    end

    // Modulo-2^W subtraction; integrator wrap cancels out here.
    assign dout = din - dly_q;

    // Delay register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: non-blocking so every flop updates from pre-edge values.
            dly_q <= '0;
        end else begin
            dly_q <= dly_d;
        end
    end

endmodule

// File: rtl/pdm_decimator.sv
// PDM -> 8-bit PCM decimator: 2nd-order CIC, fixed ratio R = 2^DECIM_LOG2.
// Integrators run on every accepted bit; the two comb stages run once per frame
// off the registered second integrator, so the strobe trails the last bit by 1 clk.
// Optional build macro PDM_DECIM_SYNC_EN: adds a 2-flop synchronizer on pdm_in/pdm_en
// for asynchronous pin sources (every event shifts by 2 clk).
module pdm_decimator
    import pdm_decimator_pkg::*;
#(
    parameter int DECIM_LOG2 = DECIM_LOG2_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    pdm_decimator_if.slave   bus
);

    localparam int W = 2 * DECIM_LOG2 + 1;
    localparam logic [DECIM_LOG2-1:0] FCNT_LAST = {DECIM_LOG2{1'b1}};

    logic pdm_bit;
    logic bit_en;

`ifdef PDM_DECIM_SYNC_EN
    logic [1:0] in_sync_q;
    logic [1:0] in_sync_d;
    logic [1:0] en_sync_q;
    logic [1:0] en_sync_d;

    // Synchronizer shift: pin value enters stage 0, stage 1 feeds the datapath.
    always_comb begin
        in_sync_d = {in_sync_q[0], bus.pdm_in};
        en_sync_d = {en_sync_q[0], bus.pdm_en};
    end

    // Two-flop synchronizer, cleared so no stale bit is accepted after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_sync_q <= '0;
            en_sync_q <= '0;
        end else begin
            in_sync_q <= in_sync_d;
            en_sync_q <= en_sync_d;
        end
    end

    assign pdm_bit = in_sync_q[1];
    assign bit_en  = en_sync_q[1];
`else
    assign pdm_bit = bus.pdm_in;
    assign bit_en  = bus.pdm_en;
`endif

    logic [W-1:0]          i1_q, i1_d;
    logic [W-1:0]          i2_q, i2_d;
    logic [DECIM_LOG2-1:0] fcnt_q, fcnt_d;
    logic                  frame_end_q, frame_end_d;
    logic [W-1:0]          c1;
    logic [W-1:0]          c2;
    warm_state_e           warm_q, warm_d;
    logic [AUDIO_W-1:0]    data_out_q, data_out_d;
    logic                  data_valid_q, data_valid_d;

    // Integrators and frame counter advance only on accepted bits.
    always_comb begin
        i1_d        = i1_q;
        i2_d        = i2_q;
        fcnt_d      = fcnt_q;
        frame_end_d = 1'b0;
        if (bit_en) begin
            i1_d        = i1_q + W'(pdm_bit);
            i2_d        = i2_q + i1_q;
            fcnt_d      = fcnt_q + DECIM_LOG2'(1);
            frame_end_d = (fcnt_q == FCNT_LAST);
        end
    end

    // Integrator, counter and frame-tick registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i1_q        <= '0;
            i2_q        <= '0;
            fcnt_q      <= '0;
            frame_end_q <= 1'b0;
        end else begin
            i1_q        <= i1_d;
            i2_q        <= i2_d;
            fcnt_q      <= fcnt_d;
            frame_end_q <= frame_end_d;
        end
    end

    // First comb differentiates the registered I2 on the tick after frame end.
    cic_comb_stage #(.W(W)) u_comb1 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (frame_end_q),
        .din   (i2_q),
        .dout  (c1)
    );

    // Second comb completes the 2nd-order response.
    cic_comb_stage #(.W(W)) u_comb2 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (frame_end_q),
        .din   (c1),
        .dout  (c2)
    );

    // Output update: the priming frame only arms warm-up, later frames publish a sample.
    always_comb begin
        warm_d       = warm_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        if (frame_end_q) begin
            if (warm_q == WARM_RUN) begin
                data_out_d   = cic_to_pcm(CIC_W_MAX'(c2), W);
                data_valid_d = 1'b1;
            end
            warm_d = WARM_RUN;
        end
    end

    // Output and warm-up registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            warm_q       <= WARM_FILL;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
        end else begin
            warm_q       <= warm_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.data_valid = data_valid_q;

endmodule

// File: tb/tb_pdm_decimator.sv
// Directed bench for pdm_decimator at DECIM_LOG2=6 (R=64).
// Inputs are driven on the falling edge, outputs sampled on the falling edge.
// A small first-order delta-sigma model stands in for the DAC in the loopback test.
module tb_pdm_decimator;

`ifdef PDM_DECIM_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif
    localparam int R         = 64;
    localparam int FIRST_LAT = 2 * R + 1 + SYNC_LAT;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pdm_decimator_if bus ();

    pdm_decimator #(.DECIM_LOG2(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Stimulus modes: 0 all zeros, 1 all ones, 2 alternating, 3 alternating with
    // pdm_en on every 2nd clk, 4 delta-sigma model of dac_d.
    int         mode  = 0;
    logic [7:0] dac_d = 8'd0;
    logic [7:0] dac_acc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Counts rising edges until data_valid is seen; a timeout counts as a failure.
    task automatic wait_strobe(input string tag, input int max_cyc, output int n);
        n = 0;
        while (n < max_cyc) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (bus.data_valid === 1'b1) return;
        end
        checks++;
        errors++;
        $error("FAIL %s timeout observed=no_strobe expected=strobe_within_%0d", tag, max_cyc);
        n = -1;
    endtask

    function automatic int absdiff(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    // Input driver: sole writer of pdm_in / pdm_en.
    initial begin
        logic [8:0] sum;
        bus.pdm_in  = 1'b0;
        bus.pdm_en  = 1'b0;
        dac_acc     = 8'd0;
        forever begin
            @(negedge clk);
            case (mode)
                0: begin bus.pdm_en = 1'b1; bus.pdm_in = 1'b0; end
                1: begin bus.pdm_en = 1'b1; bus.pdm_in = 1'b1; end
                2: begin bus.pdm_en = 1'b1; bus.pdm_in = ~bus.pdm_in; end
                3: begin
                    if (bus.pdm_en) bus.pdm_in = ~bus.pdm_in;
                    bus.pdm_en = ~bus.pdm_en;
                end
                default: begin
                    sum        = {1'b0, dac_acc} + {1'b0, dac_d};
                    dac_acc    = sum[7:0];
                    bus.pdm_in = sum[8];
                    bus.pdm_en = 1'b1;
                end
            endcase
        end
    end

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        int d;

        // ---- Test 1: constant zeros, including reset state ----
        mode = 0;
        repeat (3) @(negedge clk);
        check("reset_data_out", 32'(bus.data_out), 32'd0);
        check("reset_data_valid", 32'(bus.data_valid), 32'd0);
        rst_n = 1'b1;
        wait_strobe("zeros_first", 400, n);
        check("zeros_first_latency", 32'(n), 32'(FIRST_LAT));
        check("zeros_first_data", 32'(bus.data_out), 32'd0);
        wait_strobe("zeros_next", 200, n);
        check("zeros_spacing", 32'(n), 32'(R));
        check("zeros_next_data", 32'(bus.data_out), 32'd0);

        // ---- Test 2: constant ones saturate to 255 ----
        mode = 1;
        pulse_reset();
        wait_strobe("ones_first", 400, n);
        check("ones_first_latency", 32'(n), 32'(FIRST_LAT));
        check("ones_first_data", 32'(bus.data_out), 32'd255);
        wait_strobe("ones_next", 200, n);
        check("ones_spacing", 32'(n), 32'(R));
        check("ones_next_data", 32'(bus.data_out), 32'd255);

        // ---- Test 6: reset at fcnt=30 clears outputs immediately ----
        repeat (29) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_data_out", 32'(bus.data_out), 32'd0);
        check("midreset_data_valid", 32'(bus.data_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_strobe("midreset_first", 400, n);
        check("midreset_latency", 32'(n), 32'(FIRST_LAT));
        check("midreset_data", 32'(bus.data_out), 32'd255);

        // ---- Test 3: alternating bits give exactly mid-scale ----
        mode = 2;
        pulse_reset();
        wait_strobe("alt_first", 400, n);
        check("alt_first_latency", 32'(n), 32'(FIRST_LAT));
        check("alt_first_data", 32'(bus.data_out), 32'd128);
        for (int k = 0; k < 2; k++) begin
            wait_strobe("alt_next", 200, n);
            check("alt_spacing", 32'(n), 32'(R));
            check("alt_data", 32'(bus.data_out), 32'd128);
        end
        repeat (20) @(negedge clk);
        check("alt_hold_data", 32'(bus.data_out), 32'd128);
        check("alt_hold_valid", 32'(bus.data_valid), 32'd0);

        // ---- Test 4: pdm_en on every 2nd clk halves the strobe rate ----
        mode = 3;
        wait_strobe("gated_settle", 400, n);
        for (int k = 0; k < 2; k++) begin
            wait_strobe("gated_next", 400, n);
            check("gated_spacing", 32'(n), 32'(2 * R));
            check("gated_data", 32'(bus.data_out), 32'd128);
        end

        // ---- Test 5: delta-sigma loopback, 64 then 200 ----
        dac_d = 8'd64;
        mode  = 4;
        pulse_reset();
        wait_strobe("dac64_settle", 400, n);
        for (int k = 0; k < 2; k++) begin
            wait_strobe("dac64", 200, n);
            d = absdiff(int'(bus.data_out), 64);
            check("dac64_within_1", 32'(d <= 1), 32'd1);
        end
        dac_d = 8'd200;
        for (int k = 0; k < 2; k++) wait_strobe("dac200_settle", 200, n);
        for (int k = 0; k < 2; k++) begin
            wait_strobe("dac200", 200, n);
            d = absdiff(int'(bus.data_out), 200);
            check("dac200_within_1", 32'(d <= 1), 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
